// File: rtl/rotary_step_ctrl.sv
// Rotary step controller: turns filtered quadrature edges into bounded
// position steps with a valid/ack event handshake and post-step lockout.
module rotary_step_ctrl #(
  parameter int VAL_W    = 8,
  parameter int VAL_MIN  = 0,
  parameter int VAL_MAX  = 255,
  parameter int VAL_INIT = 0,
  parameter int STEP     = 1,
  parameter int WRAP     = 0,
  parameter int LOCKOUT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rotaf_i,
  input  logic             rotbf_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [VAL_W-1:0] load_val_i,
  input  logic             evt_ack_i,
  output logic [VAL_W-1:0] value_o,
  output logic             evt_valid_o,
  output logic             evt_dir_o,
  output logic             ovr_o,
  output logic             limit_o
);

  localparam int CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  localparam logic [VAL_W:0] MIN_X  = (VAL_W+1)'(VAL_MIN);
  localparam logic [VAL_W:0] MAX_X  = (VAL_W+1)'(VAL_MAX);
  localparam logic [VAL_W:0] STEP_X = (VAL_W+1)'(STEP);

  localparam logic [VAL_W-1:0] MIN_V  = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0] MAX_V  = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] INIT_V = VAL_W'(VAL_INIT);
  localparam logic LIMIT_INIT =
    (VAL_INIT == VAL_MIN) || (VAL_INIT == VAL_MAX);

  localparam logic [CNT_W-1:0] CNT_LD =
    CNT_W'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_prev_q;
  logic             dir_q, dir_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_dir_q, evt_dir_d;
  logic             ovr_q, ovr_d;
  logic             limit_q, limit_d;

  logic             rise;
  logic [VAL_W:0]   v_x, up_x, dn_x, ld_x;
  logic [VAL_W-1:0] step_val, load_clamp;

  assign rise = rotaf_i & ~a_prev_q;

  // Bounds are checked one bit wider so v+STEP cannot overflow silently.
  always_comb begin
    v_x  = {1'b0, value_q};
    up_x = v_x + STEP_X;
    dn_x = v_x - STEP_X;
    step_val = value_q;
    if (dir_q) begin
      if (up_x > MAX_X) begin
        step_val = (WRAP != 0) ? MIN_V : MAX_V;
      end else begin
        step_val = up_x[VAL_W-1:0];
      end
    end else begin
      if (v_x < (MIN_X + STEP_X)) begin
        step_val = (WRAP != 0) ? MAX_V : MIN_V;
      end else begin
        step_val = dn_x[VAL_W-1:0];
      end
    end
  end

  always_comb begin
    ld_x = {1'b0, load_val_i};
    load_clamp = load_val_i;
    if (ld_x <= MIN_X) begin
      load_clamp = MIN_V;
    end else if (ld_x > MAX_X) begin
      load_clamp = MAX_V;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    value_d     = value_q;
    evt_valid_d = evt_valid_q;
    evt_dir_d   = evt_dir_q;
    ovr_d       = ovr_q;

    if (evt_ack_i) begin
      evt_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rise && en_i && !load_i) begin
          state_d = UPDATE;
          dir_d   = ~rotbf_i;
        end
      end
      UPDATE: begin
        value_d     = step_val;
        evt_valid_d = 1'b1;
        evt_dir_d   = dir_q;
        if (evt_valid_q && !evt_ack_i) begin
          ovr_d = 1'b1;
        end
        if (LOCKOUT == 0) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
          cnt_d   = CNT_LD;
        end
      end
      LOCK: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load owns the value write even when a step lands in the same cycle.
    if (load_i) begin
      value_d = load_clamp;
      ovr_d   = 1'b0;
    end

    limit_d = (value_d == MIN_V) || (value_d == MAX_V);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_prev_q    <= 1'b1;
      dir_q       <= 1'b0;
      value_q     <= INIT_V;
      evt_valid_q <= 1'b0;
      evt_dir_q   <= 1'b0;
      ovr_q       <= 1'b0;
      limit_q     <= LIMIT_INIT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_prev_q    <= rotaf_i;
      dir_q       <= dir_d;
      value_q     <= value_d;
      evt_valid_q <= evt_valid_d;
      evt_dir_q   <= evt_dir_d;
      ovr_q       <= ovr_d;
      limit_q     <= limit_d;
    end
  end

  assign value_o     = value_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_dir_o   = evt_dir_q;
  assign ovr_o       = ovr_q;
  assign limit_o     = limit_q;

endmodule

// File: tb/tb_rotary_step_ctrl.sv
// Directed bench for rotary_step_ctrl: default, wrapping and 9-bit
// builds share one stimulus stream.
module tb_rotary_step_ctrl;

  logic       clk;
  logic       rst;
  logic       rotaf;
  logic       rotbf;
  logic       en;
  logic       load;
  logic [8:0] load_val;
  logic       ack;

  logic [7:0] value;
  logic       valid, dir, ovr, limit;
  logic [7:0] w_value;
  logic       w_valid, w_dir, w_ovr, w_limit;
  logic [8:0] n_value;
  logic       n_valid, n_dir, n_ovr, n_limit;

  int checks;
  int failures;

  rotary_step_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rotaf_i    (rotaf),
    .rotbf_i    (rotbf),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (load_val[7:0]),
    .evt_ack_i  (ack),
    .value_o    (value),
    .evt_valid_o(valid),
    .evt_dir_o  (dir),
    .ovr_o      (ovr),
    .limit_o    (limit)
  );

  rotary_step_ctrl #(.WRAP(1)) dut_wrap (
    .clk_i      (clk),
    .rst_i      (rst),
    .rotaf_i    (rotaf),
    .rotbf_i    (rotbf),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (load_val[7:0]),
    .evt_ack_i  (ack),
    .value_o    (w_value),
    .evt_valid_o(w_valid),
    .evt_dir_o  (w_dir),
    .ovr_o      (w_ovr),
    .limit_o    (w_limit)
  );

  rotary_step_ctrl #(.VAL_W(9)) dut_w9 (
    .clk_i      (clk),
    .rst_i      (rst),
    .rotaf_i    (rotaf),
    .rotbf_i    (rotbf),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (load_val),
    .evt_ack_i  (ack),
    .value_o    (n_value),
    .evt_valid_o(n_valid),
    .evt_dir_o  (n_dir),
    .ovr_o      (n_ovr),
    .limit_o    (n_limit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    rotaf = 1'b0;
    repeat (8) tick();
  endtask

  task automatic step(input logic bf);
    rotaf = 1'b1;
    rotbf = bf;
    tick();
    tick();
    rotaf = 1'b0;
  endtask

  task automatic do_load(input logic [8:0] v);
    load_val = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rotaf    = 1'b1;
    rotbf    = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    ack      = 1'b0;

    repeat (2) tick();
    chk("rst_value", 32'(value), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_limit", 32'(limit), 1);
    rst = 1'b0;
    repeat (3) tick();
    chk("rel_high_valid", 32'(valid), 0);
    chk("rel_high_value", 32'(value), 0);
    chk("rel_high_limit", 32'(limit), 1);

    rotaf = 1'b0;
    tick();
    rotaf = 1'b1;
    rotbf = 1'b0;
    tick();
    chk("lat_edge1", 32'(value), 0);
    tick();
    rotaf = 1'b0;
    chk("up_value", 32'(value), 1);
    chk("up_valid", 32'(valid), 1);
    chk("up_dir", 32'(dir), 1);
    chk("up_limit", 32'(limit), 0);
    do_ack();
    chk("ack_clear", 32'(valid), 0);
    settle();
    chk("ack_idle", 32'(valid), 0);

    do_load(9'd255);
    chk("ld255_value", 32'(value), 255);
    chk("ld255_limit", 32'(limit), 1);
    chk("ld255_w9", 32'(n_value), 255);
    step(1'b0);
    chk("sat_up_value", 32'(value), 255);
    chk("sat_up_valid", 32'(valid), 1);
    chk("sat_up_dir", 32'(dir), 1);
    chk("sat_up_limit", 32'(limit), 1);
    chk("sat_up_ovr", 32'(ovr), 0);
    chk("wrap_up_value", 32'(w_value), 0);
    chk("wrap_up_limit", 32'(w_limit), 1);
    do_ack();
    settle();

    do_load(9'd10);
    rotaf = 1'b1;
    rotbf = 1'b0;
    tick();
    tick();
    rotaf = 1'b0;
    tick();
    rotaf = 1'b1;
    tick();
    tick();
    chk("lock_first", 32'(value), 11);
    settle();
    chk("lock_one_step", 32'(value), 11);
    do_ack();
    settle();

    step(1'b1);
    chk("dn_value", 32'(value), 10);
    chk("dn_dir", 32'(dir), 0);
    chk("dn_ovr", 32'(ovr), 0);
    settle();
    step(1'b0);
    chk("ovr_value", 32'(value), 11);
    chk("ovr_dir", 32'(dir), 1);
    chk("ovr_flag", 32'(ovr), 1);
    chk("ovr_valid", 32'(valid), 1);
    settle();
    do_load(9'd0);
    chk("ld_clr_ovr", 32'(ovr), 0);
    chk("ld0_value", 32'(value), 0);
    chk("ld0_limit", 32'(limit), 1);
    do_ack();
    settle();

    step(1'b1);
    chk("sat_dn_value", 32'(value), 0);
    chk("sat_dn_dir", 32'(dir), 0);
    chk("sat_dn_valid", 32'(valid), 1);
    chk("wrap_dn_value", 32'(w_value), 255);
    do_ack();
    settle();
    do_load(9'd300);
    chk("clamp_w9", 32'(n_value), 255);
    chk("clamp_w9_lim", 32'(n_limit), 1);
    chk("ld_lowbits", 32'(value), 44);

    en = 1'b0;
    step(1'b0);
    settle();
    chk("en0_value", 32'(value), 44);
    chk("en0_valid", 32'(valid), 0);
    en = 1'b1;

    step(1'b0);
    chk("pre_rst_value", 32'(value), 45);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_value", 32'(value), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_dir", 32'(dir), 0);
    chk("mid_rst_ovr", 32'(ovr), 0);
    chk("mid_rst_limit", 32'(limit), 1);
    tick();
    rotaf = 1'b0;
    rst = 1'b0;
    tick();
    step(1'b0);
    chk("post_rst_value", 32'(value), 1);
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_dir", 32'(dir), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
